// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: host-loadable instruction RAM streamed in address order to the decoder over valid/ready.
// Optional feature macro IF_LOOP_EN adds fetch_loop/fetch_stop to repeat the range until stopped.
module instr_fetch_unit #(
    parameter int INSTR_W = 64,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               fetch_start,
    input  logic [ADDR_W-1:0]  fetch_base,
    input  logic [ADDR_W:0]    fetch_len,
`ifdef IF_LOOP_EN
    input  logic               fetch_loop,
    input  logic               fetch_stop,
`endif
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_instr_addr,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    logic [INSTR_W-1:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                done_q, done_d;
`ifdef IF_LOOP_EN
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                loop_q, loop_d;
    logic                stop_q, stop_d;
`endif

    logic [INSTR_W-1:0]  buf_data_q [2];
    logic [INSTR_W-1:0]  buf_data_d [2];
    logic [ADDR_W-1:0]   buf_addr_q [2];
    logic [ADDR_W-1:0]   buf_addr_d [2];
    logic                wr_sel_q, wr_sel_d;
    logic                rd_sel_q, rd_sel_d;
    logic [1:0]          count_q, count_d;

    logic                pop;
    logic                issue;

    // RAM contents are deliberately not reset so a reset does not force a reload.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    assign o_valid      = (count_q != 2'd0);
    assign o_instr      = buf_data_q[rd_sel_q];
    assign o_instr_addr = buf_addr_q[rd_sel_q];
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

    assign pop   = o_valid & i_ready;
    assign issue = (state_q == FETCH) && ((count_q != 2'd2) || pop);

    // The buffer slot is the RAM read register: a same-edge write is not yet visible, giving old data.
    always_comb begin
        buf_data_d = buf_data_q;
        buf_addr_d = buf_addr_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        count_d    = count_q;
        if (issue) begin
            buf_data_d[wr_sel_q] = mem[ptr_q];
            buf_addr_d[wr_sel_q] = ptr_q;
            wr_sel_d             = ~wr_sel_q;
        end
        if (pop) begin
            rd_sel_d = ~rd_sel_q;
        end
        case ({issue, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
`ifdef IF_LOOP_EN
        base_d  = base_q;
        len_d   = len_q;
        loop_d  = loop_q;
        stop_d  = stop_q;
`endif
        case (state_q)
            IDLE: begin
                if (fetch_start) begin
                    if (fetch_len != '0) begin
                        state_d = FETCH;
                        ptr_d   = fetch_base;
                        rem_d   = fetch_len;
`ifdef IF_LOOP_EN
                        base_d  = fetch_base;
                        len_d   = fetch_len;
                        loop_d  = fetch_loop;
                        stop_d  = 1'b0;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
`ifdef IF_LOOP_EN
                if (fetch_stop) begin
                    stop_d = 1'b1;
                end
`endif
                if (issue) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    rem_d = rem_q - (ADDR_W+1)'(1);
                    if (rem_q == (ADDR_W+1)'(1)) begin
`ifdef IF_LOOP_EN
                        // A stop raised during this pass lets the pass finish before draining.
                        if (loop_q && !(stop_q || fetch_stop)) begin
                            ptr_d = base_q;
                            rem_d = len_q;
                        end else begin
                            state_d = DRAIN;
                        end
`else
                        state_d = DRAIN;
`endif
                    end
                end
            end
            DRAIN: begin
                if ((count_q == 2'd1) && pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_addr_q[i] <= '0;
            end
`ifdef IF_LOOP_EN
            base_q   <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
            stop_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            count_q    <= count_d;
            buf_data_q <= buf_data_d;
            buf_addr_q <= buf_addr_d;
`ifdef IF_LOOP_EN
            base_q     <= base_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            stop_q     <= stop_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: expected words are queued at start and compared at each handshake.
// The loop scenario is compiled in only when IF_LOOP_EN is defined.
module tb_instr_fetch_unit;

    localparam int INSTR_W = 64;
    localparam int DEPTH   = 32;
    localparam int ADDR_W  = 5;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               load_en;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;
    logic               fetch_start;
    logic [ADDR_W-1:0]  fetch_base;
    logic [ADDR_W:0]    fetch_len;
`ifdef IF_LOOP_EN
    logic               fetch_loop;
    logic               fetch_stop;
`endif
    logic [INSTR_W-1:0] o_instr;
    logic [ADDR_W-1:0]  o_instr_addr;
    logic               o_valid;
    logic               i_ready;
    logic               busy;
    logic               done;

    exp_t               sb_q[$];
    bit                 ready_pat[$];
    logic [INSTR_W-1:0] shadow [DEPTH];

    int cyc          = 0;
    int assert_count = 0;
    int fail_count   = 0;
    int hs_count     = 0;
    int first_hs_cyc = -1;
    int last_hs_cyc  = -1;

    logic               prev_stall = 1'b0;
    logic [INSTR_W-1:0] prev_data  = '0;
    logic [ADDR_W-1:0]  prev_addr  = '0;

    instr_fetch_unit #(
        .INSTR_W(INSTR_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .fetch_start (fetch_start),
        .fetch_base  (fetch_base),
        .fetch_len   (fetch_len),
`ifdef IF_LOOP_EN
        .fetch_loop  (fetch_loop),
        .fetch_stop  (fetch_stop),
`endif
        .o_instr     (o_instr),
        .o_instr_addr(o_instr_addr),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Consumer-side ready pattern, one entry per cycle; ready defaults high once the pattern is used up.
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ready_pat.size() > 0) i_ready = ready_pat.pop_front();
            else                      i_ready = 1'b1;
        end
    end

    // Handshake monitor: scoreboard compare plus hold-stable check across stalls.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", 64'(o_valid), 64'd1);
                checkOutput("stall_data", o_instr, prev_data);
                checkOutput("stall_addr", 64'(o_instr_addr), 64'(prev_addr));
            end
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_word", 64'(o_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("word_data", o_instr, e.data);
                    checkOutput("word_addr", 64'(o_instr_addr), 64'(e.addr));
                end
                hs_count++;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
            end
            prev_stall = o_valid && !i_ready;
            prev_data  = o_instr;
            prev_addr  = o_instr_addr;
        end
    end

    task automatic loadWord(input int addr, input logic [INSTR_W-1:0] data);
        load_en      = 1'b1;
        load_addr    = ADDR_W'(addr);
        load_data    = data;
        shadow[addr] = data;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic applyStimulus(input int base, input int len, input int passes, output int t_start);
        exp_t e;
        t_start      = cyc;
        first_hs_cyc = -1;
        fetch_start  = 1'b1;
        fetch_base   = ADDR_W'(base);
        fetch_len    = (ADDR_W+1)'(len);
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < len; i++) begin
                e.addr = ADDR_W'((base + i) % DEPTH);
                e.data = shadow[(base + i) % DEPTH];
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        fetch_start = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) checkOutput("done_timeout", 64'(done), 64'd1);
        else              checkOutput("busy_at_done", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkSeq(input int hs_before, input int n, input int done_cyc);
        checkOutput("hs_count", 64'(hs_count - hs_before), 64'(n));
        checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
        checkOutput("done_after_last", 64'(done_cyc), 64'(last_hs_cyc + 1));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t;
        int d;
        int hs0;
        rst         = 1'b1;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        fetch_start = 1'b0;
        fetch_base  = '0;
        fetch_len   = '0;
`ifdef IF_LOOP_EN
        fetch_loop  = 1'b0;
        fetch_stop  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 64'(o_valid), 64'd0);
        checkOutput("rst_instr", o_instr, 64'd0);
        checkOutput("rst_addr", 64'(o_instr_addr), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) loadWord(i, 64'h1000 + 64'(i));

        // Basic sequence: latency and throughput
        hs0 = hs_count;
        applyStimulus(0, 4, 1, t);
        @(negedge clk);
        checkOutput("busy_t1", 64'(busy), 64'd1);
        checkOutput("valid_t1", 64'(o_valid), 64'd0);
        @(posedge clk);
        #1;
        waitDone(20, d);
        checkOutput("first_word_cycle", 64'(first_hs_cyc), 64'(t + 2));
        checkOutput("done_cycle", 64'(d), 64'(t + 6));
        checkSeq(hs0, 4, d);

        // Address wrap
        hs0 = hs_count;
        applyStimulus(30, 4, 1, t);
        waitDone(20, d);
        checkOutput("wrap_done_cycle", 64'(d), 64'(t + 6));
        checkSeq(hs0, 4, d);

        // Backpressure with ready 1,0,0,1,1,0,1 starting at T+2
        hs0 = hs_count;
        ready_pat = '{1, 1, 1, 0, 0, 1, 1, 0, 1};
        applyStimulus(0, 4, 1, t);
        waitDone(30, d);
        checkOutput("stall_done_cycle", 64'(d), 64'(t + 9));
        checkSeq(hs0, 4, d);
        ready_pat.delete();

        // Zero-length fetch
        hs0 = hs_count;
        applyStimulus(3, 0, 1, t);
        @(negedge clk);
        checkOutput("len0_done", 64'(done), 64'd1);
        checkOutput("len0_busy", 64'(busy), 64'd0);
        checkOutput("len0_valid", 64'(o_valid), 64'd0);
        @(negedge clk);
        checkOutput("len0_done_pulse", 64'(done), 64'd0);
        checkOutput("len0_busy2", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("len0_no_words", 64'(hs_count - hs0), 64'd0);

        // Start while busy is ignored
        hs0 = hs_count;
        applyStimulus(8, 4, 1, t);
        @(posedge clk);
        #1;
        fetch_start = 1'b1;
        fetch_base  = ADDR_W'(20);
        fetch_len   = (ADDR_W+1)'(2);
        @(posedge clk);
        #1;
        fetch_start = 1'b0;
        waitDone(20, d);
        checkOutput("ignored_done_cycle", 64'(d), 64'(t + 6));
        checkSeq(hs0, 4, d);

        // Load to a not-yet-read address during the fetch
        hs0 = hs_count;
        shadow[15] = 64'hABCD_0000_0000_000F;
        applyStimulus(10, 6, 1, t);
        loadWord(15, 64'hABCD_0000_0000_000F);
        waitDone(20, d);
        checkSeq(hs0, 6, d);

        // Full-depth fetch from a non-zero base
        hs0 = hs_count;
        applyStimulus(7, DEPTH, 1, t);
        waitDone(60, d);
        checkOutput("full_done_cycle", 64'(d), 64'(t + DEPTH + 2));
        checkSeq(hs0, DEPTH, d);

        // Reset after two of eight handshakes
        hs0 = hs_count;
        applyStimulus(0, 8, 1, t);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (hs_count - hs0 >= 2) break;
        end
        checkOutput("rst_wait_hs", 64'(hs_count - hs0), 64'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        checkOutput("midrst_valid", 64'(o_valid), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midrst_no_done", 64'(done), 64'd0);
            checkOutput("midrst_no_valid", 64'(o_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        hs0 = hs_count;
        applyStimulus(5, 1, 1, t);
        waitDone(20, d);
        checkOutput("post_rst_first", 64'(first_hs_cyc), 64'(t + 2));
        checkOutput("post_rst_done", 64'(d), 64'(t + 3));
        checkSeq(hs0, 1, d);

        // Random bases, lengths and ready patterns
        for (int it = 0; it < 3; it++) begin
            int b;
            int n;
            b = int'($urandom_range(0, DEPTH - 1));
            n = int'($urandom_range(1, DEPTH));
            for (int k = 0; k < 60; k++) ready_pat.push_back($urandom_range(0, 3) != 0);
            hs0 = hs_count;
            applyStimulus(b, n, 1, t);
            waitDone(200, d);
            checkSeq(hs0, n, d);
            ready_pat.delete();
        end

`ifdef IF_LOOP_EN
        // Loop over 2,3 and stop during the third pass
        hs0 = hs_count;
        fetch_loop = 1'b1;
        applyStimulus(2, 2, 3, t);
        fetch_loop = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        fetch_stop = 1'b1;
        @(posedge clk);
        #1;
        fetch_stop = 1'b0;
        waitDone(30, d);
        checkOutput("loop_done_cycle", 64'(d), 64'(t + 8));
        checkSeq(hs0, 6, d);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Parametrised instruction fetch unit for the accelerator control path.
- Holds a host-loadable instruction RAM.
- On command, streams a contiguous address range to the decoder over a valid/ready handshake.
- Replaces the fixed-table, fixed-count fetcher with configurable width, depth, base and length, plus backpressure support.
- Sits between the host/DMA instruction loader and the instruction decoder.

Parameters:
INSTR_W, 64, instruction word width in bits
DEPTH, 32, instruction RAM entries; power of two, at least 4
ADDR_W, 5, log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  reset
load_en  in  1  write strobe into instruction RAM
load_addr  in  ADDR_W  write address
load_data  in  INSTR_W  write data
fetch_start  in  1  start pulse; sampled only in IDLE
fetch_base  in  ADDR_W  first instruction address; sampled with fetch_start
fetch_len  in  ADDR_W+1  instruction count, 0..DEPTH; sampled with fetch_start
o_instr  out  INSTR_W  instruction word
o_instr_addr  out  ADDR_W  RAM address of o_instr
o_valid  out  1  o_instr/o_instr_addr valid
i_ready  in  1  decoder accepts; handshake = o_valid & i_ready
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of sequence

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset: state IDLE, o_valid=0, o_instr=0, o_instr_addr=0, busy=0, done=0, read pointer and remaining count = 0.
- Reset mid-operation aborts the sequence and discards all pending reads and buffered words. RAM contents are not cleared.
- RAM: one write port (load_en) and one synchronous read port, read latency 1.
  - Same-cycle read and write to the same address returns the old data.
  - Writes are accepted in every state.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: fetch_start=1 with fetch_len>0 → FETCH. Latch ptr=fetch_base, remaining=fetch_len.
  - IDLE: fetch_start=1 with fetch_len=0 → stay IDLE; done=1 next cycle; no output.
  - FETCH: issue one RAM read per cycle while the output buffer has room. Each issue: ptr increments modulo DEPTH (wrap DEPTH-1 → 0), remaining decrements. When the last read is issued → DRAIN.
  - DRAIN: wait until the output buffer is empty and the last word has handshaken → IDLE. done=1 in the cycle after the final handshake; busy falls in the same cycle.
- fetch_start while busy is ignored and has no side effects.
- Output buffer: 2 entries, so full throughput is kept under a registered i_ready.
  - o_instr, o_instr_addr and o_valid hold stable while o_valid=1 and i_ready=0.
  - Words are presented in strict address order, with no duplication and no loss.
- Latency: start accepted at cycle T → first read issued at T+1 → o_valid=1 at T+2 with instr[fetch_base].
- Throughput: with i_ready held at 1, one word per cycle. N words handshake at T+2..T+N+1; done=1 at T+N+2.
- fetch_len=DEPTH fetches every entry exactly once, starting at fetch_base and wrapping.
- A load to an address not yet read during the sequence is picked up by the fetch.

Optional Feature:
IF_LOOP_EN.
- When defined, adds inputs fetch_loop (1 bit, sampled with fetch_start) and fetch_stop (1 bit).
- With fetch_loop=1: after issuing the last read, ptr reloads fetch_base and remaining reloads fetch_len, and the range repeats indefinitely.
- fetch_stop=1 during a loop: the current pass finishes, then the FSM goes to DRAIN and done pulses as normal.
- fetch_stop in IDLE is ignored.
- Not defined: ports absent; every sequence is single-pass.

Test Plan:
- Load addr 0..31 with 64'h1000+addr; start base=0, len=4, i_ready=1 → o_valid at T+2..T+5 with 0x1000..0x1003, addr 0..3; done at T+6.
- Start base=30, len=4 → addr sequence 30,31,0,1 and data 0x101E,0x101F,0x1000,0x1001.
- len=4, i_ready pattern 1,0,0,1,1,0,1 → words stay stable during stalls; exactly 4 handshakes, in order; done 1 cycle after the 4th.
- fetch_len=0 → no o_valid; done=1 at T+1; busy stays 0. Second fetch_start while busy → ignored; the sequence completes unchanged.
- rst asserted after 2 of 8 handshakes → next cycle o_valid=0, busy=0, no done. New start base=5, len=1 → instr[5] at T+2.
- IF_LOOP_EN: base=2, len=2, fetch_loop=1 → addr 2,3,2,3,…; assert fetch_stop mid-pass → current pass completes, then done.
